gcd_ctrl: RTL

- Control FSM for the subtract-and-swap GCD datapath: two 16-bit load-enabled parallel registers A and B, a shared subtractor, input mux and comparator.
- Sequences operand loading from the shared data bus, then issues one conditional subtraction per cycle until the operands are equal or a zero or timeout condition is detected.
- Exposes a start/busy/done/err handshake to the requester and a register-select for reading the result.

---
 rtl/gcd_ctrl_pkg.sv | 19 +
 rtl/gcd_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl_pkg.sv
// Shared constants for the subtract-and-swap GCD controller and its datapath:
// state encodings, mux select codes and datapath width.
package gcd_ctrl_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic SEL_SUB_AMB = 1'b0;
    localparam logic SEL_SUB_BMA = 1'b1;
    localparam logic SEL_EXT     = 1'b1;
    localparam logic SEL_SUB     = 1'b0;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-and-swap GCD datapath: loads A and B from the
// shared bus, then issues one conditional subtraction per cycle until finished.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | operand A on data_in, register A loads
// LOAD_B | operand B on data_in, register B loads
// RUN    | one compare/subtract per cycle
// DONE   | result valid in register selected by res_sel
// ERR    | both operands zero or iteration limit reached
module gcd_ctrl
    import gcd_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             ld_a,
    output logic             ld_b,
    output logic             sel_in,
    output logic             sel_sub,
    output logic             res_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       res_sel_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       at_max;

    assign at_max = (iter_cnt == MAX_CNT);

    always_comb begin
        state_nxt   = state;
        res_sel_nxt = res_sel;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        sel_in      = SEL_SUB;
        sel_sub     = SEL_SUB_AMB;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD_A;
                    cnt_clr   = 1'b1;
                end
            end
            S_LOAD_A: begin
                busy      = 1'b1;
                ld_a      = 1'b1;
                sel_in    = SEL_EXT;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                busy      = 1'b1;
                ld_b      = 1'b1;
                sel_in    = SEL_EXT;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // Zero and equality checks outrank the limit so a finished
                // computation is never reported as a timeout.
                if (a_zero && b_zero) begin
                    state_nxt = S_ERR;
                end else if (a_zero) begin
                    state_nxt   = S_DONE;
                    res_sel_nxt = 1'b1;
                end else if (b_zero || eq) begin
                    state_nxt   = S_DONE;
                    res_sel_nxt = 1'b0;
                end else if (at_max) begin
                    state_nxt = S_ERR;
                end else if (gt) begin
                    ld_a    = 1'b1;
                    sel_sub = SEL_SUB_AMB;
                    cnt_inc = 1'b1;
                end else if (lt) begin
                    ld_b    = 1'b1;
                    sel_sub = SEL_SUB_BMA;
                    cnt_inc = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                done = (state == S_DONE);
                err  = (state == S_ERR);
                if (start) begin
                    state_nxt = S_LOAD_A;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt   = S_IDLE;
            res_sel_nxt = res_sel;
            cnt_clr     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            res_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            res_sel <= res_sel_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (cnt_clr) begin
            iter_cnt <= '0;
        end else if (cnt_inc && !at_max) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

endmodule
